sram_ctrl: RTL and testbench

- Synchronous controller that sits directly upstream of the asynchronous 16-bit SRAM.
- Turns single-cycle read/write requests from the core/bus side into properly timed notCS/notOE/notWE strobes, a stable address and a bidirectional data bus.
- Registers read data and returns it with a one-cycle response strobe.
- Wait-state counts are parameters, sized so the 55 ns SRAM access fits at a 100 MHz clock.

---
 rtl/sram_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sram_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous front end for an asynchronous 16-bit SRAM.
// A single-cycle request handshake (req_*) is turned into registered,
// glitch-free notCS/notOE/notWE strobes, a stable address and a
// bidirectional data bus. Read data is registered and returned with a
// one-cycle rsp_valid strobe.
//
// Ports:
//   clk, notReset            clock, asynchronous active-low reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_write/addr/wdata     request payload
//   rsp_valid/rsp_rdata      read response strobe and held read data
//   mem_addr, mem_data       SRAM address and bidirectional data bus
//   mem_notCS/OE/WE          SRAM strobes, active low
module sram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned RD_WAIT    = 6,
  parameter int unsigned WR_WAIT    = 4,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  notReset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_notCS,
  output logic                  mem_notOE,
  output logic                  mem_notWE
);

  // Counters are loaded with N-1 and the phase ends when they reach zero.
  localparam logic [7:0] L_SETUP = 8'(SETUP_CYC - 1);
  localparam logic [7:0] L_RD    = 8'(RD_WAIT - 1);
  localparam logic [7:0] L_WR    = 8'(WR_WAIT - 1);
  localparam logic [7:0] L_HOLD  = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RD_ACC,
    S_WR_PULSE,
    S_HOLD
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [7:0]              r_cnt;
  logic                    w_cnt_zero;
  logic                    r_write;
  logic                    r_drive;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_rsp;
  logic                    r_notCS;
  logic                    r_notOE;
  logic                    r_notWE;

  assign w_cnt_zero = (r_cnt == 8'd0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (req_valid)  w_state_nxt = S_SETUP;
      S_SETUP:    if (w_cnt_zero) w_state_nxt = r_write ? S_WR_PULSE : S_RD_ACC;
      S_RD_ACC:   if (w_cnt_zero) w_state_nxt = S_HOLD;
      S_WR_PULSE: if (w_cnt_zero) w_state_nxt = S_HOLD;
      S_HOLD:     if (w_cnt_zero) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Strobes and bus enable are registered alongside the state so every
  // SRAM-facing signal comes straight from a flop.
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_drive <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rsp   <= 1'b0;
      r_notCS <= 1'b1;
      r_notOE <= 1'b1;
      r_notWE <= 1'b1;
    end else begin
      r_rsp <= 1'b0;
      if (!w_cnt_zero) r_cnt <= r_cnt - 8'd1;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_drive <= req_write;
            r_notCS <= 1'b0;
            r_cnt   <= L_SETUP;
          end
        end
        S_SETUP: begin
          if (w_cnt_zero) begin
            if (r_write) begin
              r_notWE <= 1'b0;
              r_cnt   <= L_WR;
            end else begin
              r_notOE <= 1'b0;
              r_cnt   <= L_RD;
            end
          end
        end
        S_RD_ACC: begin
          if (w_cnt_zero) begin
            r_rdata <= mem_data;
            r_rsp   <= 1'b1;
            r_notOE <= 1'b1;
            r_notCS <= 1'b1;
            r_cnt   <= L_HOLD;
          end
        end
        S_WR_PULSE: begin
          if (w_cnt_zero) begin
            r_notWE <= 1'b1;
            r_notCS <= 1'b1;
            r_cnt   <= L_HOLD;
          end
        end
        S_HOLD: begin
          // Write data stays on the bus through the hold window.
          if (w_cnt_zero) r_drive <= 1'b0;
        end
        default: begin
          r_notCS <= 1'b1;
          r_notOE <= 1'b1;
          r_notWE <= 1'b1;
          r_drive <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp;
  assign rsp_rdata = r_rdata;
  assign mem_addr  = r_addr;
  assign mem_notCS = r_notCS;
  assign mem_notOE = r_notOE;
  assign mem_notWE = r_notWE;
  assign mem_data  = r_drive ? r_wdata : 'z;

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

  logic        clk;
  logic        notReset;
  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;

  logic        a_valid, a_ready, a_rsp, a_cs, a_oe, a_we;
  logic [15:0] a_rdata, a_addr;
  wire  [15:0] a_data;
  logic        b_valid, b_ready, b_rsp, b_cs, b_oe, b_we;
  logic [15:0] b_rdata, b_addr;
  wire  [15:0] b_data;

  logic [15:0] memA [0:65535];
  logic [15:0] memB [0:65535];

  int total = 0;
  int bad   = 0;

  assign a_valid = req_valid & ~sel;
  assign b_valid = req_valid & sel;

  sram_ctrl u_a (
    .clk(clk), .notReset(notReset),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(a_rsp), .rsp_rdata(a_rdata),
    .mem_addr(a_addr), .mem_data(a_data),
    .mem_notCS(a_cs), .mem_notOE(a_oe), .mem_notWE(a_we)
  );

  sram_ctrl #(.SETUP_CYC(1), .RD_WAIT(1), .WR_WAIT(1), .HOLD_CYC(3)) u_b (
    .clk(clk), .notReset(notReset),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(b_rsp), .rsp_rdata(b_rdata),
    .mem_addr(b_addr), .mem_data(b_data),
    .mem_notCS(b_cs), .mem_notOE(b_oe), .mem_notWE(b_we)
  );

  // Zero-delay SRAM models: drive while CS and OE are low, commit on WE rise.
  assign a_data = (!a_cs && !a_oe) ? memA[a_addr] : 'z;
  assign b_data = (!b_cs && !b_oe) ? memB[b_addr] : 'z;

  always @(posedge a_we) if (notReset) memA[a_addr] = a_data;
  always @(posedge b_we) if (notReset) memB[b_addr] = b_data;

  // Selected-DUT views
  logic        s_ready, s_rsp, s_cs, s_oe, s_we;
  logic [15:0] s_rdata, s_addr;
  assign s_ready = sel ? b_ready : a_ready;
  assign s_rsp   = sel ? b_rsp   : a_rsp;
  assign s_cs    = sel ? b_cs    : a_cs;
  assign s_oe    = sel ? b_oe    : a_oe;
  assign s_we    = sel ? b_we    : a_we;
  assign s_rdata = sel ? b_rdata : a_rdata;
  assign s_addr  = sel ? b_addr  : a_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Protocol invariants: OE/WE never both low; address stable while CS low.
  logic        p_a_cs_low, p_b_cs_low;
  logic [15:0] p_a_addr, p_b_addr;
  initial begin
    p_a_cs_low = 1'b0;
    p_b_cs_low = 1'b0;
    p_a_addr   = '0;
    p_b_addr   = '0;
  end
  always @(negedge clk) begin
    if (notReset) begin
      if (!a_oe && !a_we) chk("a_oe_we_overlap", 1, 0);
      if (!b_oe && !b_we) chk("b_oe_we_overlap", 1, 0);
      if (p_a_cs_low && !a_cs && a_addr != p_a_addr) chk("a_addr_stable", a_addr, p_a_addr);
      if (p_b_cs_low && !b_cs && b_addr != p_b_addr) chk("b_addr_stable", b_addr, p_b_addr);
    end
    p_a_cs_low = !a_cs;
    p_b_cs_low = !b_cs;
    p_a_addr   = a_addr;
    p_b_addr   = b_addr;
  end

  // One isolated transfer, started at a negedge with the DUT idle.
  task automatic txn(input logic s, input logic wr, input logic [15:0] addr,
                     input logic [15:0] wdata, input logic [15:0] exp_rdata,
                     input int exp_busy, input int exp_rsp, input int exp_we,
                     input string nm);
    int busy, rsp_at, rsp_cnt, we_cnt;
    sel = s; req_write = wr; req_addr = addr; req_wdata = wdata;
    #1;
    chk({nm, "_ready_pre"}, s_ready, 1);
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk({nm, "_addr"}, s_addr, addr);
    chk({nm, "_cs"}, s_cs, 0);
    busy = -1; rsp_at = -1; rsp_cnt = 0; we_cnt = 0;
    for (int n = 0; n < 64; n++) begin
      if (n > 0) @(negedge clk);
      if (s_rsp) begin rsp_cnt++; rsp_at = n; end
      if (!s_we) we_cnt++;
      if (s_ready) begin busy = n; break; end
    end
    chk({nm, "_busy"}, busy, exp_busy);
    chk({nm, "_we_cycles"}, we_cnt, exp_we);
    if (wr) begin
      chk({nm, "_rsp_cnt"}, rsp_cnt, 0);
    end else begin
      chk({nm, "_rsp_cnt"}, rsp_cnt, 1);
      chk({nm, "_rsp_at"}, rsp_at, exp_rsp);
      chk({nm, "_rdata"}, s_rdata, exp_rdata);
    end
  endtask

  typedef struct {
    logic        s;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_busy;
    int          exp_rsp;
    int          exp_we;
  } vec_t;

  vec_t vecs [0:9];
  vec_t bb   [0:3];

  initial begin
    // Preload: mem[i] = i ^ 0x5A5A
    for (int i = 0; i < 65536; i++) begin
      memA[i] = 16'(i) ^ 16'h5A5A;
      memB[i] = 16'(i) ^ 16'h5A5A;
    end

    //           s  wr  addr      wdata     exp_rd    busy rsp we
    vecs[0] = '{1'b0, 1'b1, 16'h0042, 16'h1234, 16'h0000, 6, -1, 4};
    vecs[1] = '{1'b0, 1'b0, 16'h0042, 16'h0000, 16'h1234, 8,  7, 0};
    vecs[2] = '{1'b0, 1'b1, 16'h1000, 16'hBEEF, 16'h0000, 6, -1, 4};
    vecs[3] = '{1'b0, 1'b0, 16'h1000, 16'h0000, 16'hBEEF, 8,  7, 0};
    vecs[4] = '{1'b0, 1'b0, 16'h0007, 16'h0000, 16'h5A5D, 8,  7, 0};
    vecs[5] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 6, -1, 4};
    vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 8,  7, 0};
    vecs[7] = '{1'b1, 1'b1, 16'h0010, 16'hC3C3, 16'h0000, 5, -1, 1};
    vecs[8] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hC3C3, 5,  2, 0};
    vecs[9] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h5A7A, 5,  2, 0};

    bb[0] = '{1'b0, 1'b1, 16'h0000, 16'hAAAA, 16'h0000, 6, -1, 4};
    bb[1] = '{1'b0, 1'b1, 16'hFFFF, 16'h5555, 16'h0000, 6, -1, 4};
    bb[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hAAAA, 8,  7, 0};
    bb[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h5555, 8,  7, 0};

    // Reset with a request pending: nothing may start.
    sel = 1'b0; req_write = 1'b1; req_addr = 16'h0042; req_wdata = 16'h1234;
    req_valid = 1'b1;
    notReset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", a_cs, 1);
    chk("rst_oe", a_oe, 1);
    chk("rst_we", a_we, 1);
    chk("rst_rsp", a_rsp, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_addr", a_addr, 0);
    req_valid = 1'b0;
    notReset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_cs", a_cs, 1);

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
          vecs[i].exp_busy, vecs[i].exp_rsp, vecs[i].exp_we, $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Back-to-back with req_valid held high throughout.
    sel = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int busy, rsp_at;
      logic [15:0] got;
      req_write = bb[i].wr; req_addr = bb[i].addr; req_wdata = bb[i].wdata;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bb%0d_addr", i), a_addr, bb[i].addr);
      busy = -1; rsp_at = -1; got = '0;
      for (int n = 0; n < 64; n++) begin
        if (n > 0) @(negedge clk);
        if (a_rsp) begin rsp_at = n; got = a_rdata; end
        if (a_ready) begin busy = n; break; end
      end
      chk($sformatf("bb%0d_busy", i), busy, bb[i].exp_busy);
      if (!bb[i].wr) begin
        chk($sformatf("bb%0d_rsp_at", i), rsp_at, bb[i].exp_rsp);
        chk($sformatf("bb%0d_rdata", i), got, bb[i].exp_rdata);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);

    // Reset during the second WR_PULSE cycle.
    sel = 1'b0; req_write = 1'b1; req_addr = 16'h0200; req_wdata = 16'h7777;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_we_low", a_we, 0);
    notReset = 1'b0;
    #1;
    chk("mid_rst_cs", a_cs, 1);
    chk("mid_rst_we", a_we, 1);
    chk("mid_rst_oe", a_oe, 1);
    chk("mid_rst_ready", a_ready, 1);
    @(negedge clk);
    notReset = 1'b1;
    @(negedge clk);
    chk("mid_post_ready", a_ready, 1);
    chk("mid_post_rsp", a_rsp, 0);
    txn(1'b0, 1'b0, 16'h0100, 16'h0000, 16'h5B5A, 8, 7, 0, "post_rst_rd");

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
